// File: rtl/mem_access_stage.sv
// Data-memory access stage: one outstanding load/store,
// misalignment check, bus timeout and in-flight kill.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        RegWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  WA3M,
    input  logic        flush_m,
    output logic        stall_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    output logic        RegWriteO,
    output logic        MemtoRegO,
    output logic        mem_err,
    output logic [31:0] ReadDataO,
    output logic [31:0] ALUOutO,
    output logic [3:0]  WA3O
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  state;
    logic [7:0]  cnt;
    logic        kill;
    logic        we_q;
    logic        ld_q;
    logic        rw_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wa_q;

    logic access;
    logic aligned;
    logic busy;
    logic timeout_hit;
    logic start;
    logic finish;
    logic killed;

    assign access      = in_valid & (MemWriteM | MemtoRegM) & ~flush_m;
    assign aligned     = (ALUOutM[1:0] == 2'b00);
    assign busy        = (state == BUSY);
    assign timeout_hit = busy & (cnt == CNT_LAST);
    assign start       = ~busy & access & aligned;
    assign finish      = busy & (mem_ack | timeout_hit);
    // A flush arriving in the completion cycle still kills the result
    assign killed      = kill | flush_m;

    assign stall_m   = start | (busy & ~mem_ack & ~timeout_hit);
    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Sequence IDLE/BUSY, count unanswered BUSY cycles, remember flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            kill  <= 1'b0;
        end else if (start) begin
            state <= BUSY;
            cnt   <= '0;
            kill  <= 1'b0;
        end else if (finish) begin
            state <= IDLE;
        end else if (busy) begin
            cnt <= cnt + 8'd1;
            if (flush_m) begin
                kill <= 1'b1;
            end
        end
    end

    // Capture the access so the bus stays stable for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wa_q    <= '0;
        end else if (start) begin
            we_q    <= MemWriteM;
            ld_q    <= MemtoRegM;
            rw_q    <= RegWriteM;
            addr_q  <= ALUOutM;
            wdata_q <= WriteDataM;
            wa_q    <= WA3M;
        end
    end

    // Result register towards MEM/WB; fields hold while out_valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            RegWriteO <= 1'b0;
            MemtoRegO <= 1'b0;
            mem_err   <= 1'b0;
            ReadDataO <= '0;
            ALUOutO   <= '0;
            WA3O      <= '0;
        end else begin
            out_valid <= 1'b0;
            RegWriteO <= 1'b0;
            if (busy) begin
                if (finish & killed) begin
                    mem_err <= 1'b0;
                end else if (finish) begin
                    out_valid <= 1'b1;
                    ALUOutO   <= addr_q;
                    WA3O      <= wa_q;
                    MemtoRegO <= ld_q;
                    if (mem_ack) begin
                        RegWriteO <= rw_q;
                        mem_err   <= 1'b0;
                        ReadDataO <= ld_q ? mem_rdata : 32'd0;
                    end else begin
                        mem_err   <= 1'b1;
                        ReadDataO <= '0;
                    end
                end
            end else if (in_valid & ~flush_m) begin
                if (~access) begin
                    out_valid <= 1'b1;
                    RegWriteO <= RegWriteM;
                    MemtoRegO <= MemtoRegM;
                    mem_err   <= 1'b0;
                    ReadDataO <= '0;
                    ALUOutO   <= ALUOutM;
                    WA3O      <= WA3M;
                end else if (~aligned) begin
                    out_valid <= 1'b1;
                    MemtoRegO <= MemtoRegM;
                    mem_err   <= 1'b1;
                    ReadDataO <= '0;
                    ALUOutO   <= ALUOutM;
                    WA3O      <= WA3M;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vectors, randomized
// transactions against a transaction-level model, reset cases.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic [3:0]  WA3M = '0;
    logic        flush_m = 1'b0;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        out_valid;
    logic        RegWriteO;
    logic        MemtoRegO;
    logic        mem_err;
    logic [31:0] ReadDataO;
    logic [31:0] ALUOutO;
    logic [3:0]  WA3O;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .RegWriteM(RegWriteM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .WA3M(WA3M),
        .flush_m(flush_m), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .RegWriteO(RegWriteO),
        .MemtoRegO(MemtoRegO), .mem_err(mem_err),
        .ReadDataO(ReadDataO), .ALUOutO(ALUOutO),
        .WA3O(WA3O)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        we;
        logic        ld;
        logic        rw;
        logic        fl;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  wa;
    } ins_t;

    typedef struct {
        int          reqs;
        int          stalls;
        logic        hung;
        logic        idle_req;
        logic        unstable;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ov;
        logic        rw;
        logic        err;
        logic        mto;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [3:0]  wa;
    } obs_t;

    typedef struct {
        int          reqs;
        int          stalls;
        logic        ov;
        logic        rw;
        logic        err;
        logic        mto;
        logic        chk_err;
        logic        full;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [3:0]  wa;
    } exp_t;

    typedef struct {
        string       nm;
        ins_t        i;
        int          ack;
        int          fa;
        logic [31:0] rd;
        logic        ai;
    } sc_t;

    // Transaction-level expectation: ack/flush given as BUSY-cycle index
    function automatic exp_t model(ins_t i, int ack, int fa,
                                   logic [31:0] rd);
        exp_t e;
        int   done;
        bit   acked;
        e = '{default: '0};
        if (!i.v || i.fl) return e;
        if (!(i.we || i.ld)) begin
            e.ov = 1; e.rw = i.rw; e.chk_err = 1; e.full = 1;
            e.alu = i.alu; e.wa = i.wa;
            return e;
        end
        if (i.alu[1:0] != 2'b00) begin
            e.ov = 1; e.err = 1; e.chk_err = 1;
            return e;
        end
        acked = (ack >= 0 && ack < TO);
        done = acked ? ack : TO - 1;
        e.reqs = done + 1;
        e.stalls = done + 1;
        e.chk_err = 1;
        if (fa >= 0 && fa <= done) return e;
        e.ov = 1;
        if (acked) begin
            e.rw = i.rw; e.full = 1; e.mto = i.ld;
            e.rd = i.ld ? rd : 32'd0;
            e.alu = i.alu; e.wa = i.wa;
        end else begin
            e.err = 1;
        end
        return e;
    endfunction

    // Present one instruction, act as memory, collect what happened
    task automatic issue(input ins_t i, input int ack, input int fa,
                         input logic [31:0] rd, input logic ai,
                         output obs_t o);
        o = '{default: '0};
        @(negedge clk);
        in_valid = i.v; MemWriteM = i.we; MemtoRegM = i.ld;
        RegWriteM = i.rw; ALUOutM = i.alu; WriteDataM = i.wd;
        WA3M = i.wa; flush_m = i.fl; mem_ack = ai; mem_rdata = rd;
        #1;
        o.stalls = stall_m ? 1 : 0;
        o.idle_req = mem_req;
        @(posedge clk);
        o.hung = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            flush_m = (c == fa);
            mem_ack = (c == ack);
            #1;
            if (!mem_req) begin
                o.hung = 1'b0;
                break;
            end
            o.reqs++;
            if (stall_m) o.stalls++;
            if (o.reqs == 1) begin
                o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
            end else if (mem_we !== o.we || mem_addr !== o.addr ||
                         mem_wdata !== o.wdata) begin
                o.unstable = 1'b1;
            end
            @(posedge clk);
        end
        o.ov = out_valid; o.rw = RegWriteO; o.err = mem_err;
        o.mto = MemtoRegO; o.rd = ReadDataO; o.alu = ALUOutO;
        o.wa = WA3O;
        in_valid = 1'b0; flush_m = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, RegWriteO, MemtoRegO, mem_err} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {out_valid, RegWriteO, MemtoRegO, mem_err});
        end
        n_cmp++;
        if ({ReadDataO, ALUOutO, WA3O} !== 68'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h want 0",
                     ReadDataO, ALUOutO, WA3O);
        end
        n_cmp++;
        if ({mem_req, stall_m} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_bus: got %b want 00", {mem_req, stall_m});
        end
    endtask

    task automatic test_directed();
        sc_t  t[$];
        obs_t o;
        exp_t e;
        t.push_back('{"load_ack3", {5'b10110, 32'h100, 32'h0, 4'd5},
                      3, -1, 32'hDEADBEEF, 1'b0});
        t.push_back('{"store_ack0", {5'b11000, 32'h204, 32'h12345678, 4'd0},
                      0, -1, 32'h0, 1'b0});
        t.push_back('{"load_misal", {5'b10110, 32'h102, 32'h0, 4'd7},
                      0, -1, 32'h0, 1'b0});
        t.push_back('{"timeout", {5'b10110, 32'h40, 32'h0, 4'd2},
                      -1, -1, 32'h0, 1'b0});
        t.push_back('{"flush_busy", {5'b10110, 32'h80, 32'h0, 4'd9},
                      3, 1, 32'h11112222, 1'b0});
        t.push_back('{"add_ack_idle", {5'b10010, 32'hCAFE0001, 32'h0, 4'd3},
                      -1, -1, 32'h0, 1'b1});
        t.push_back('{"flushed_in", {5'b10111, 32'h100, 32'h0, 4'd4},
                      0, -1, 32'h0, 1'b0});
        t.push_back('{"store_misal", {5'b11000, 32'h203, 32'hAA, 4'd0},
                      0, -1, 32'h0, 1'b0});
        t.push_back('{"ack_late", {5'b11000, 32'h300, 32'h55, 4'd0},
                      5, -1, 32'h0, 1'b0});
        t.push_back('{"ack_tie", {5'b10100, 32'h308, 32'h0, 4'd1},
                      TO - 1, -1, 32'h600DF00D, 1'b0});
        t.push_back('{"bubble", {5'b00000, 32'h0, 32'h0, 4'd0},
                      -1, -1, 32'h0, 1'b1});
        foreach (t[k]) begin
            e = model(t[k].i, t[k].ack, t[k].fa, t[k].rd);
            issue(t[k].i, t[k].ack, t[k].fa, t[k].rd, t[k].ai, o);
            n_cmp++;
            if (o.hung !== 1'b0 || o.idle_req !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hang/idle_req: got %b%b want 00",
                         t[k].nm, o.hung, o.idle_req);
            end
            n_cmp++;
            if (o.reqs != e.reqs || o.stalls != e.stalls) begin
                n_bad++;
                $display("FAIL %s req/stall cycles: got %0d/%0d want %0d/%0d",
                         t[k].nm, o.reqs, o.stalls, e.reqs, e.stalls);
            end
            n_cmp++;
            if (o.ov !== e.ov || o.rw !== e.rw) begin
                n_bad++;
                $display("FAIL %s valid/regwrite: got %b%b want %b%b",
                         t[k].nm, o.ov, o.rw, e.ov, e.rw);
            end
            if (e.chk_err) begin
                n_cmp++;
                if (o.err !== e.err) begin
                    n_bad++;
                    $display("FAIL %s mem_err: got %b want %b",
                             t[k].nm, o.err, e.err);
                end
            end
            if (e.full) begin
                n_cmp++;
                if (o.rd !== e.rd || o.alu !== e.alu ||
                    o.wa !== e.wa || o.mto !== e.mto) begin
                    n_bad++;
                    $display("FAIL %s data: got %h %h %h %b want %h %h %h %b",
                             t[k].nm, o.rd, o.alu, o.wa, o.mto,
                             e.rd, e.alu, e.wa, e.mto);
                end
            end
            if (e.reqs > 0) begin
                n_cmp++;
                if (o.we !== t[k].i.we || o.addr !== t[k].i.alu ||
                    o.wdata !== t[k].i.wd || o.unstable !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s bus: got %b %h %h u%b want %b %h %h u0",
                             t[k].nm, o.we, o.addr, o.wdata, o.unstable,
                             t[k].i.we, t[k].i.alu, t[k].i.wd);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            ins_t        i;
            int          k;
            int          ack;
            int          fa;
            logic [31:0] rd;
            logic        ai;
            obs_t        o;
            exp_t        e;
            k = int'($urandom_range(0, 9));
            i.v = (k != 0);
            i.fl = (k == 1);
            i.we = 1'b0;
            i.ld = (k == 1);
            if (k >= 5) begin
                if ($urandom_range(0, 1) == 1) i.we = 1'b1;
                else i.ld = 1'b1;
            end
            i.rw = i.we ? 1'b0 : 1'($urandom_range(0, 1));
            i.alu = $urandom;
            if (k >= 5 && $urandom_range(0, 4) != 0) i.alu[1:0] = 2'b00;
            i.wd = $urandom;
            i.wa = 4'($urandom);
            ack = int'($urandom_range(0, 6)) - 1;
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            rd = $urandom;
            ai = 1'($urandom_range(0, 1));
            e = model(i, ack, fa, rd);
            issue(i, ack, fa, rd, ai, o);
            n_cmp++;
            if (o.hung !== 1'b0 || o.idle_req !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d hang/idle_req: got %b%b want 00",
                         n, o.hung, o.idle_req);
            end
            n_cmp++;
            if (o.reqs != e.reqs || o.stalls != e.stalls) begin
                n_bad++;
                $display("FAIL rand%0d req/stall cycles: got %0d/%0d want %0d/%0d",
                         n, o.reqs, o.stalls, e.reqs, e.stalls);
            end
            n_cmp++;
            if (o.ov !== e.ov || o.rw !== e.rw) begin
                n_bad++;
                $display("FAIL rand%0d valid/regwrite: got %b%b want %b%b",
                         n, o.ov, o.rw, e.ov, e.rw);
            end
            if (e.chk_err) begin
                n_cmp++;
                if (o.err !== e.err) begin
                    n_bad++;
                    $display("FAIL rand%0d mem_err: got %b want %b",
                             n, o.err, e.err);
                end
            end
            if (e.full) begin
                n_cmp++;
                if (o.rd !== e.rd || o.alu !== e.alu ||
                    o.wa !== e.wa || o.mto !== e.mto) begin
                    n_bad++;
                    $display("FAIL rand%0d data: got %h %h %h %b want %h %h %h %b",
                             n, o.rd, o.alu, o.wa, o.mto,
                             e.rd, e.alu, e.wa, e.mto);
                end
            end
            if (e.reqs > 0) begin
                n_cmp++;
                if (o.we !== i.we || o.addr !== i.alu ||
                    o.wdata !== i.wd || o.unstable !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand%0d bus: got %b %h %h u%b want %b %h %h u0",
                             n, o.we, o.addr, o.wdata, o.unstable,
                             i.we, i.alu, i.wd);
                end
            end
        end
    endtask

    task automatic test_hold();
        ins_t add;
        ins_t nop;
        obs_t o;
        add = {5'b10010, 32'h0BADC0DE, 32'h0, 4'd11};
        nop = '0;
        issue(add, -1, -1, 32'h0, 1'b0, o);
        n_cmp++;
        if (o.ov !== 1'b1 || o.alu !== 32'h0BADC0DE) begin
            n_bad++;
            $display("FAIL hold_setup: got %b %h want 1 0badc0de", o.ov, o.alu);
        end
        issue(nop, -1, -1, 32'h0, 1'b0, o);
        n_cmp++;
        if (o.ov !== 1'b0 || o.rw !== 1'b0 ||
            o.alu !== 32'h0BADC0DE || o.wa !== 4'd11) begin
            n_bad++;
            $display("FAIL hold: got %b %b %h %h want 0 0 0badc0de b",
                     o.ov, o.rw, o.alu, o.wa);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; MemWriteM = 1'b0; MemtoRegM = 1'b0;
        RegWriteM = 1'b1; ALUOutM = 32'h00000111; WA3M = 4'd1;
        #1;
        n_cmp++;
        if (stall_m !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_add1_stall: got %b want 0", stall_m);
        end
        @(posedge clk);
        @(negedge clk);
        MemtoRegM = 1'b1; ALUOutM = 32'h00001000; WA3M = 4'd6;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || ALUOutO !== 32'h111 || WA3O !== 4'd1 ||
            stall_m !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_add1_out: got %b %h %h st%b want 1 111 1 st1",
                     out_valid, ALUOutO, WA3O, stall_m);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (stall_m !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_busy: got st%b ov%b want st1 ov0",
                     stall_m, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5F00D;
        #1;
        n_cmp++;
        if (stall_m !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ack_stall: got %b want 0", stall_m);
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0; MemtoRegM = 1'b0;
        ALUOutM = 32'h00000333; WA3M = 4'd3;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || ReadDataO !== 32'hA5A5F00D ||
            WA3O !== 4'd6 || RegWriteO !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_load_out: got %b %h %h %b want 1 a5a5f00d 6 1",
                     out_valid, ReadDataO, WA3O, RegWriteO);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || ALUOutO !== 32'h333 || WA3O !== 4'd3) begin
            n_bad++;
            $display("FAIL b2b_add2_out: got %b %h %h want 1 333 3",
                     out_valid, ALUOutO, WA3O);
        end
    endtask

    task automatic test_rst_busy();
        @(negedge clk);
        in_valid = 1'b1; MemWriteM = 1'b0; MemtoRegM = 1'b1;
        RegWriteM = 1'b1; ALUOutM = 32'h00000500; WA3M = 4'd8;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || stall_m !== 1'b0 || out_valid !== 1'b0 ||
            RegWriteO !== 1'b0 || ALUOutO !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_busy: got %b %b %b %b %h want 0 0 0 0 0",
                     mem_req, stall_m, out_valid, RegWriteO, ALUOutO);
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hBAADBAAD;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_late_req: got %b want 0", mem_req);
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || RegWriteO !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_late_ack: got %b%b want 00",
                     out_valid, RegWriteO);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_random();
        test_rst_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
